// File: rtl/cpu_sequencer.sv
`default_nettype none
// =============================================================================
// Module      : cpu_sequencer
// Description : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning PC and IR.
// Revision    : 1.0 - initial release
// =============================================================================
module cpu_sequencer #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] HALT_INSTR  = 16'hFFFF,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] instr,
  input  logic        jump,
  input  logic        branch,
  input  logic        memwrite,
  input  logic        memtoreg,
  input  logic        regwrite,
  input  logic        is_zero,
  input  logic        mem_ready,
  output logic [15:0] pc,
  output logic [15:0] ir,
  output logic        reg_we,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  state,
  output logic        halted,
  output logic        fault,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] retired_q, retired_d;
  logic [15:0] mem_cnt_q, mem_cnt_d;
  logic        fault_q, fault_d;
  logic        retire;
  logic [15:0] pc_inc;
  logic [15:0] br_target;

  assign pc_inc    = pc_q + 16'd1;
  // Branch offset is a signed 7-bit displacement relative to pc+1.
  assign br_target = pc_inc + {{9{ir_q[6]}}, ir_q[6:0]};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    mem_cnt_d = mem_cnt_q;
    fault_d   = fault_q;
    retire    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_d    = instr;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = (ir_q == HALT_INSTR) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (jump) begin
          pc_d    = {pc_q[15:13], ir_q[12:0]};
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (branch) begin
          pc_d    = is_zero ? br_target : pc_inc;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (memwrite || memtoreg) begin
          mem_cnt_d = 16'd0;
          state_d   = S_MEM;
        end else if (regwrite) begin
          state_d = S_WB;
        end else begin
          pc_d    = pc_inc;
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (memtoreg) begin
            state_d = S_WB;
          end else begin
            pc_d    = pc_inc;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else if ((TIMEOUT != 16'd0) && (mem_cnt_q + 16'd1 == TIMEOUT)) begin
          // Abandon the access: the instruction is not retired and pc stays put.
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          mem_cnt_d = mem_cnt_q + 16'd1;
        end
      end
      S_WB: begin
        pc_d    = pc_inc;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    retired_d = (retire && (retired_q != 16'hFFFF)) ? retired_q + 16'd1 : retired_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= 16'd0;
      retired_q <= 16'd0;
      mem_cnt_q <= 16'd0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      mem_cnt_q <= mem_cnt_d;
      fault_q   <= fault_d;
    end
  end

  assign pc      = pc_q;
  assign ir      = ir_q;
  assign state   = state_q;
  assign retired = retired_q;
  assign fault   = fault_q;
  assign halted  = (state_q == S_HALT);
  assign reg_we  = (state_q == S_WB);
  assign mem_req = (state_q == S_MEM);
  assign mem_we  = (state_q == S_MEM) && memwrite;

endmodule
`default_nettype wire
